// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; zero-latency lookup, registered update.
// Define BRANCH_PREDICTOR_STATS_EN to add update/mispredict statistics counters.
module branch_predictor #(
  parameter int         ENTRIES  = 64,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_pc_i,
  output logic        hit_o,
  output logic        predict_taken_o,
  output logic [31:0] next_pc_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  output logic        mispredict_o
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_updates_o,
  output logic [31:0] stat_mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tags    [ENTRIES];
  logic [31:0]      targets [ENTRIES];
  logic [1:0]       ctr     [ENTRIES];

  logic [IDX_W-1:0] lidx;
  logic [TAG_W-1:0] ltag;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic             upred;
  logic             mis;
  logic             unused_ok;

  assign lidx = lookup_pc_i[IDX_W+1:2];
  assign ltag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign uidx = update_pc_i[IDX_W+1:2];
  assign utag = update_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Low and high PC bits take no part in indexing or tagging.
  assign unused_ok = &{1'b0, lookup_pc_i, update_pc_i};

  assign hit_o           = valid[lidx] && (tags[lidx] == ltag);
  assign predict_taken_o = hit_o && ctr[lidx][1];
  assign next_pc_o       = predict_taken_o ? targets[lidx]
                                           : lookup_pc_i + 32'd4;

  assign uhit  = valid[uidx] && (tags[uidx] == utag);
  assign upred = uhit && ctr[uidx][1];
  assign mis   = (upred != update_taken_i) ||
                 (upred && update_taken_i &&
                  (targets[uidx] != update_target_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= CTR_INIT;
      end
      mispredict_o <= 1'b0;
    end else begin
      mispredict_o <= update_valid_i && mis;
      if (update_valid_i) begin
        if (uhit) begin
          if (update_taken_i) begin
            if (ctr[uidx] != 2'b11) ctr[uidx] <= ctr[uidx] + 2'd1;
          end else begin
            if (ctr[uidx] != 2'b00) ctr[uidx] <= ctr[uidx] - 2'd1;
          end
        end else if (update_taken_i) begin
          valid[uidx] <= 1'b1;
          ctr[uidx]   <= 2'b10;
        end
      end
    end
  end

  // Tag and target storage carry no reset; valid gates them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && update_valid_i && update_taken_i) begin
      targets[uidx] <= update_target_i;
      if (!uhit) tags[uidx] <= utag;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_updates_o     <= 32'd0;
      stat_mispredicts_o <= 32'd0;
    end else if (update_valid_i) begin
      stat_updates_o <= stat_updates_o + 32'd1;
      if (mis) stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
    end
  end
`endif

endmodule
